// File: rtl/clusterv_sysbus_arb.sv
// ---------------------------------------------------------------------------
// clusterv_sysbus_arb
//   Round-robin Wishbone arbiter that shares one 32-bit system-bus target port
//   between N initiators (management interface, peripheral DMA, ...).
//   An owner keeps the bus for as long as it holds cyc, so multi-beat cycles
//   are never split. A watchdog errors a strobe that the target leaves
//   unanswered for TIMEOUT cycles.
//
// Ports
//   clock, reset       system clock, asynchronous active-low reset
//   i_adr/i_dat_w/i_sel/i_cyc/i_stb/i_we
//                      per-initiator request, initiator k at slice k
//   i_dat_r            target read data, broadcast to every initiator
//   i_ack, i_err       per-initiator response, only the owner ever sees one
//   t_*                target-side request / response
//   grant              one-hot current owner, zero when idle
//   timeout_evt        one-cycle pulse when the watchdog errors a strobe
// ---------------------------------------------------------------------------

// Per-initiator slice: request detect, request masking and response steering.
// Every non-owner lane drives zeros so the top can OR the lanes together.
module clusterv_sysbus_arb_lane #(
    parameter int ADR_WIDTH = 32,
    parameter int DAT_WIDTH = 32,
    parameter int SEL_WIDTH = 4
) (
    input  logic                 own,
    input  logic                 toerr,
    input  logic                 gnt,
    input  logic [ADR_WIDTH-1:0] adr,
    input  logic [DAT_WIDTH-1:0] dat_w,
    input  logic [SEL_WIDTH-1:0] sel,
    input  logic                 cyc,
    input  logic                 stb,
    input  logic                 we,
    input  logic                 t_ack,
    input  logic                 t_err,
    output logic                 req,
    output logic [ADR_WIDTH-1:0] adr_m,
    output logic [DAT_WIDTH-1:0] dat_m,
    output logic [SEL_WIDTH-1:0] sel_m,
    output logic                 cyc_m,
    output logic                 stb_m,
    output logic                 we_m,
    output logic                 ack,
    output logic                 err,
    output logic                 gcyc
);
    logic active;

    assign active = own & gnt;
    assign req    = cyc & stb;

    assign adr_m  = active ? adr   : '0;
    assign dat_m  = active ? dat_w : '0;
    assign sel_m  = active ? sel   : '0;
    assign cyc_m  = active & cyc;
    assign stb_m  = active & stb;
    assign we_m   = active & we;

    // Target responses reach the owner only while it owns the bus; the
    // watchdog error is delivered in the timeout cycle regardless of target.
    assign ack    = active & t_ack;
    assign err    = (active & t_err) | (toerr & gnt);

    // Owner's cyc independent of state, so the timeout cycle can decide
    // whether to hand the bus back to the owner or release it.
    assign gcyc   = gnt & cyc;
endmodule

module clusterv_sysbus_arb #(
    parameter int N_INITIATORS = 2,
    parameter int ADR_WIDTH    = 32,
    parameter int DAT_WIDTH    = 32,
    parameter int TIMEOUT      = 255
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [N_INITIATORS*ADR_WIDTH-1:0]     i_adr,
    input  logic [N_INITIATORS*DAT_WIDTH-1:0]     i_dat_w,
    output logic [DAT_WIDTH-1:0]                  i_dat_r,
    input  logic [N_INITIATORS-1:0]               i_cyc,
    input  logic [N_INITIATORS-1:0]               i_stb,
    input  logic [N_INITIATORS-1:0]               i_we,
    input  logic [N_INITIATORS*(DAT_WIDTH/8)-1:0] i_sel,
    output logic [N_INITIATORS-1:0]               i_ack,
    output logic [N_INITIATORS-1:0]               i_err,
    output logic [ADR_WIDTH-1:0]                  t_adr,
    output logic [DAT_WIDTH-1:0]                  t_dat_w,
    output logic [DAT_WIDTH/8-1:0]                t_sel,
    output logic                                  t_cyc,
    output logic                                  t_stb,
    output logic                                  t_we,
    input  logic [DAT_WIDTH-1:0]                  t_dat_r,
    input  logic                                  t_ack,
    input  logic                                  t_err,
    output logic [N_INITIATORS-1:0]               grant,
    output logic                                  timeout_evt
);
    localparam int          SEL_WIDTH = DAT_WIDTH / 8;
    localparam int          GW        = $clog2(N_INITIATORS);
    localparam logic [15:0] WD_LAST   = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, OWN, TOERR} state_t;

    state_t          state;
    logic [GW-1:0]   last_grant;
    logic [15:0]     wdog;
    logic            own;
    logic            toerr;

    logic [N_INITIATORS-1:0]                req;
    logic [N_INITIATORS-1:0]                cyc_v;
    logic [N_INITIATORS-1:0]                stb_v;
    logic [N_INITIATORS-1:0]                we_v;
    logic [N_INITIATORS-1:0]                gcyc_v;
    logic [N_INITIATORS-1:0][ADR_WIDTH-1:0] adr_v;
    logic [N_INITIATORS-1:0][DAT_WIDTH-1:0] dat_v;
    logic [N_INITIATORS-1:0][SEL_WIDTH-1:0] sel_v;

    logic            owner_cyc;
    logic            waiting;
    logic [GW-1:0]   winner;
    logic            found;
    int              idx;

    assign own         = (state == OWN);
    assign toerr       = (state == TOERR);
    assign timeout_evt = toerr;
    assign i_dat_r     = t_dat_r;

    genvar k;
    generate
        for (k = 0; k < N_INITIATORS; k++) begin : g_lane
            clusterv_sysbus_arb_lane #(
                .ADR_WIDTH(ADR_WIDTH),
                .DAT_WIDTH(DAT_WIDTH),
                .SEL_WIDTH(SEL_WIDTH)
            ) u_lane (
                .own   (own),
                .toerr (toerr),
                .gnt   (grant[k]),
                .adr   (i_adr[k*ADR_WIDTH +: ADR_WIDTH]),
                .dat_w (i_dat_w[k*DAT_WIDTH +: DAT_WIDTH]),
                .sel   (i_sel[k*SEL_WIDTH +: SEL_WIDTH]),
                .cyc   (i_cyc[k]),
                .stb   (i_stb[k]),
                .we    (i_we[k]),
                .t_ack (t_ack),
                .t_err (t_err),
                .req   (req[k]),
                .adr_m (adr_v[k]),
                .dat_m (dat_v[k]),
                .sel_m (sel_v[k]),
                .cyc_m (cyc_v[k]),
                .stb_m (stb_v[k]),
                .we_m  (we_v[k]),
                .ack   (i_ack[k]),
                .err   (i_err[k]),
                .gcyc  (gcyc_v[k])
            );
        end
    endgenerate

    // Grant is one-hot, so OR-ing the masked lanes is the owner mux.
    always_comb begin
        t_adr   = '0;
        t_dat_w = '0;
        t_sel   = '0;
        for (int i = 0; i < N_INITIATORS; i++) begin
            t_adr   = t_adr   | adr_v[i];
            t_dat_w = t_dat_w | dat_v[i];
            t_sel   = t_sel   | sel_v[i];
        end
    end

    assign t_cyc     = |cyc_v;
    assign t_stb     = |stb_v;
    assign t_we      = |we_v;
    assign owner_cyc = |gcyc_v;
    assign waiting   = t_cyc & t_stb & ~t_ack & ~t_err;

    // Round-robin pick: first requester strictly after the previous winner.
    always_comb begin
        winner = last_grant;
        found  = 1'b0;
        idx    = 0;
        for (int i = 1; i <= N_INITIATORS; i++) begin
            idx = (int'(last_grant) + i) % N_INITIATORS;
            if (!found && req[idx]) begin
                winner = GW'(idx);
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= GW'(N_INITIATORS - 1);
            wdog       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wdog <= '0;
                    if (|req) begin
                        grant      <= N_INITIATORS'(1) << winner;
                        last_grant <= winner;
                        state      <= OWN;
                    end
                end
                OWN: begin
                    if (!owner_cyc) begin
                        // Release always goes through IDLE, even when the
                        // same initiator asks again straight away.
                        state <= IDLE;
                        grant <= '0;
                        wdog  <= '0;
                    end else if (waiting) begin
                        if (wdog == WD_LAST) begin
                            state <= TOERR;
                            wdog  <= '0;
                        end else if (wdog != 16'hFFFF) begin
                            wdog  <= wdog + 16'd1;
                        end
                    end else begin
                        wdog <= '0;
                    end
                end
                TOERR: begin
                    // Pointer is left alone: a timeout is not a new grant.
                    wdog <= '0;
                    if (owner_cyc) begin
                        state <= OWN;
                    end else begin
                        state <= IDLE;
                        grant <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    wdog  <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_clusterv_sysbus_arb.sv
// ---------------------------------------------------------------------------
// tb_clusterv_sysbus_arb
//   Directed scenarios (reset, single transfer, locked burst, watchdog,
//   isolation, reset mid-read) followed by a randomized two-initiator phase
//   checked against a transaction-level round-robin model.
// ---------------------------------------------------------------------------
module tb_clusterv_sysbus_arb;
    localparam int NI  = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TO  = 16;

    logic               clock;
    logic               reset;
    logic [NI*AW-1:0]   i_adr;
    logic [NI*DW-1:0]   i_dat_w;
    logic [DW-1:0]      i_dat_r;
    logic [NI-1:0]      i_cyc, i_stb, i_we;
    logic [NI*SW-1:0]   i_sel;
    logic [NI-1:0]      i_ack, i_err;
    logic [AW-1:0]      t_adr;
    logic [DW-1:0]      t_dat_w;
    logic [SW-1:0]      t_sel;
    logic               t_cyc, t_stb, t_we;
    logic [DW-1:0]      t_dat_r;
    logic               t_ack, t_err;
    logic [NI-1:0]      grant;
    logic               timeout_evt;

    int errors = 0;
    int checks = 0;

    clusterv_sysbus_arb #(
        .N_INITIATORS(NI), .ADR_WIDTH(AW), .DAT_WIDTH(DW), .TIMEOUT(TO)
    ) dut (
        .clock(clock), .reset(reset),
        .i_adr(i_adr), .i_dat_w(i_dat_w), .i_dat_r(i_dat_r),
        .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_sel(i_sel),
        .i_ack(i_ack), .i_err(i_err),
        .t_adr(t_adr), .t_dat_w(t_dat_w), .t_sel(t_sel),
        .t_cyc(t_cyc), .t_stb(t_stb), .t_we(t_we),
        .t_dat_r(t_dat_r), .t_ack(t_ack), .t_err(t_err),
        .grant(grant), .timeout_evt(timeout_evt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Next owner: first requester found walking upward from last+1, wrapping.
    function automatic int rr_next(input int last, input logic [NI-1:0] r);
        for (int i = 1; i <= NI; i++)
            if (r[(last + i) % NI]) return (last + i) % NI;
        return last;
    endfunction

    // Randomized-phase model state
    int            lastm;
    logic [NI-1:0] pg, pcyc, eg;
    bit            act  [NI];
    bit            ackd [NI];
    int            gap  [NI];
    logic [31:0]   radr [NI];
    int            tcnt;
    int            own_i;
    bit            etc;
    logic [31:0]   rdat;

    initial begin
        reset   = 1'b0;
        i_adr   = '0; i_dat_w = '0; i_cyc = '0; i_stb = '0; i_we = '0; i_sel = '0;
        t_dat_r = '0; t_ack = 1'b0; t_err = 1'b0;

        // ---- reset state
        tick(); tick();
        t_dat_r = 32'h1234_5678;
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_t_cyc", t_cyc, 0);
        chk("rst_t_stb", t_stb, 0);
        chk("rst_t_adr", t_adr, 0);
        chk("rst_i_ack", i_ack, 0);
        chk("rst_i_err", i_err, 0);
        chk("rst_tmo",   timeout_evt, 0);
        chk("rst_dat_r", i_dat_r, 32'h1234_5678);
        reset = 1'b1;
        tick();

        // ---- single write from initiator 0, acked on the 3rd bus cycle
        i_adr[0 +: AW] = 32'h3000_0010; i_dat_w[0 +: DW] = 32'hA5A5_0001;
        i_we[0] = 1'b1; i_sel[0 +: SW] = 4'hF; i_cyc[0] = 1'b1; i_stb[0] = 1'b1;
        #1;
        chk("single_latency", t_cyc, 0);
        tick();
        chk("single_grant", grant, 2'b01);
        chk("single_t_cyc", t_cyc, 1);
        chk("single_t_adr", t_adr, 32'h3000_0010);
        chk("single_t_dat", t_dat_w, 32'hA5A5_0001);
        chk("single_t_we",  t_we, 1);
        chk("single_t_sel", t_sel, 4'hF);
        chk("single_noack", i_ack, 0);
        tick();
        chk("single_noack2", i_ack, 0);
        tick();
        t_ack = 1'b1; #1;
        chk("single_ack", i_ack, 2'b01);
        tick();
        t_ack = 1'b0; i_cyc[0] = 1'b0; i_stb[0] = 1'b0; #1;
        chk("single_ack_once", i_ack, 0);
        chk("single_hold", grant, 2'b01);
        tick();
        chk("single_release", grant, 2'b00);

        // ---- locked 4-beat burst from initiator 1 while initiator 0 waits
        i_adr[AW +: AW] = 32'h4000_0000; i_we[1] = 1'b0; i_sel[SW +: SW] = 4'h3;
        i_cyc[1] = 1'b1; i_stb[1] = 1'b1;
        tick();
        chk("burst_grant", grant, 2'b10);
        i_adr[0 +: AW] = 32'h3000_0020; i_we[0] = 1'b0;
        i_cyc[0] = 1'b1; i_stb[0] = 1'b1;
        for (int b = 0; b < 4; b++) begin
            i_adr[AW +: AW] = 32'h4000_0000 + 32'(b * 4);
            t_ack = 1'b1; #1;
            chk("burst_lock", grant, 2'b10);
            chk("burst_ack", i_ack, 2'b10);
            chk("burst_adr", t_adr, 32'h4000_0000 + 32'(b * 4));
            tick();
        end
        t_ack = 1'b0; i_cyc[1] = 1'b0; i_stb[1] = 1'b0; #1;
        chk("burst_cyc_drop", t_cyc, 0);
        chk("burst_hold", grant, 2'b10);
        tick();
        chk("burst_idle", grant, 2'b00);
        tick();
        chk("burst_next", grant, 2'b01);

        // ---- watchdog: initiator 0 is owner, target never answers
        for (int w = 0; w < TO; w++) begin
            chk("wd_wait_cyc", t_cyc, 1);
            chk("wd_wait_tmo", timeout_evt, 0);
            tick();
        end
        chk("wd_tmo", timeout_evt, 1);
        chk("wd_err", i_err, 2'b01);
        chk("wd_t_cyc", t_cyc, 0);
        chk("wd_t_stb", t_stb, 0);
        t_ack = 1'b1; #1;
        chk("wd_late_ack", i_ack, 0);
        t_ack = 1'b0; i_cyc[0] = 1'b0; i_stb[0] = 1'b0;
        tick();
        chk("wd_pulse_end", timeout_evt, 0);
        chk("wd_release", grant, 0);
        tick(); tick();
        t_ack = 1'b1; #1;
        chk("wd_stray_ack", i_ack, 0);
        chk("wd_stray_err", i_err, 0);
        t_ack = 1'b0;

        // ---- isolation: t_err while initiator 1 owns the bus
        i_cyc[1] = 1'b1; i_stb[1] = 1'b1;
        tick();
        chk("iso_grant", grant, 2'b10);
        t_err = 1'b1; t_dat_r = 32'hDEAD_BEEF; #1;
        chk("iso_err", i_err, 2'b10);
        chk("iso_ack", i_ack, 0);
        chk("iso_dat_r", i_dat_r, 32'hDEAD_BEEF);
        tick();
        t_err = 1'b0; i_cyc[1] = 1'b0; i_stb[1] = 1'b0;
        tick();

        // ---- reset mid-read
        i_cyc[0] = 1'b1; i_stb[0] = 1'b1;
        tick();
        chk("rmid_grant", grant, 2'b01);
        i_cyc[1] = 1'b1; i_stb[1] = 1'b1; t_ack = 1'b1;
        reset = 1'b0; #1;
        chk("rmid_t_cyc", t_cyc, 0);
        chk("rmid_grant0", grant, 0);
        chk("rmid_ack", i_ack, 0);
        tick();
        i_cyc[0] = 1'b0; i_stb[0] = 1'b0; t_ack = 1'b0; reset = 1'b1;
        tick();
        chk("rmid_first", grant, 2'b10);
        i_cyc[1] = 1'b0; i_stb[1] = 1'b0;
        tick(); tick();

        // ---- randomized two-initiator traffic against the round-robin model
        lastm = 1; pg = '0; pcyc = '0; tcnt = 0;
        for (int k = 0; k < NI; k++) begin
            act[k] = 1'b0; ackd[k] = 1'b0; gap[k] = $urandom_range(0, 2); radr[k] = '0;
        end
        for (int c = 0; c < 800; c++) begin
            tick();
            if (pg == '0) begin
                if (pcyc != '0) begin
                    lastm = rr_next(lastm, pcyc);
                    eg    = NI'(1) << lastm;
                end else begin
                    eg = '0;
                end
            end else begin
                eg = ((pg & pcyc) != '0) ? pg : '0;
            end
            chk("rnd_grant", grant, 32'(eg));

            for (int k = 0; k < NI; k++) begin
                if (act[k]) begin
                    if (ackd[k]) begin
                        act[k] = 1'b0;
                        gap[k] = $urandom_range(0, 3);
                    end
                end else if (gap[k] == 0) begin
                    act[k]  = 1'b1;
                    radr[k] = $urandom;
                    i_adr[k*AW +: AW]   = radr[k];
                    i_dat_w[k*DW +: DW] = $urandom;
                    i_we[k]             = 1'($urandom_range(0, 1));
                    i_sel[k*SW +: SW]   = 4'($urandom_range(0, 15));
                end else begin
                    gap[k]--;
                end
                i_cyc[k] = act[k];
                i_stb[k] = act[k];
            end

            own_i = 0;
            for (int k = 0; k < NI; k++) if (eg[k]) own_i = k;
            etc = (eg != '0) && act[own_i];

            // Target answers a strobe after 0..3 extra cycles
            if (!etc) begin
                tcnt  = $urandom_range(0, 3);
                t_ack = 1'b0;
            end else if (tcnt == 0) begin
                t_ack = 1'b1;
            end else begin
                tcnt--;
                t_ack = 1'b0;
            end
            rdat = $urandom;
            t_dat_r = rdat;
            #1;
            chk("rnd_t_cyc", t_cyc, 32'(etc));
            if (etc) chk("rnd_t_adr", t_adr, radr[own_i]);
            chk("rnd_i_ack", i_ack, (etc && t_ack) ? 32'(eg) : 32'd0);
            chk("rnd_i_err", i_err, 0);
            chk("rnd_dat_r", i_dat_r, rdat);
            for (int k = 0; k < NI; k++) ackd[k] = etc && t_ack && eg[k];
            pg   = eg;
            for (int k = 0; k < NI; k++) pcyc[k] = act[k];
        end

        i_cyc = '0; i_stb = '0; t_ack = 1'b0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
